// File: rtl/sap1_ucode_pkg.sv
// Shared micro-code definitions for the SAP-1 microsequencer: opcodes,
// micro-op and sequencing encodings, routine base addresses and field widths.
package sap1_ucode_pkg;

  localparam int UPC_W_DEF = 5;
  localparam int OPC_W_DEF = 4;
  localparam int UOP_W     = 4;
  localparam int SEQ_W     = 2;

  localparam logic [3:0] OPC_LDA = 4'b0000;
  localparam logic [3:0] OPC_ADD = 4'b0001;
  localparam logic [3:0] OPC_SUB = 4'b0010;
  localparam logic [3:0] OPC_OUT = 4'b1110;
  localparam logic [3:0] OPC_HLT = 4'b1111;

  typedef enum logic [UOP_W-1:0] {
    UOP_NOP,
    UOP_EP_LM,
    UOP_CP,
    UOP_CE_LI,
    UOP_EI_LM,
    UOP_CE_LA,
    UOP_CE_LB,
    UOP_ADD,
    UOP_SUB,
    UOP_EA_LO,
    UOP_HALT,
    UOP_ILL
  } uop_t;

  typedef enum logic [SEQ_W-1:0] {
    SEQ_INC  = 2'b00,
    SEQ_MAP  = 2'b01,
    SEQ_CLR  = 2'b10,
    SEQ_HOLD = 2'b11
  } seq_t;

  typedef struct packed {
    uop_t uop;
    seq_t seq;
  } uword_t;

  // Entry points of the fetch block and each execute routine
  localparam int FETCH_BASE = 0;
  localparam int LDA_BASE   = 4;
  localparam int ADD_BASE   = 6;
  localparam int SUB_BASE   = 9;
  localparam int OUT_BASE   = 12;
  localparam int HLT_BASE   = 13;
  localparam int ILL_BASE   = 14;

  typedef struct packed {
    logic ep;
    logic cp;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } strobes_t;

endpackage

// File: rtl/sap1_microsequencer_if.sv
// Bundle between the microsequencer (master) and the SAP-1 datapath (slave):
// step enable and IR opcode in, datapath strobes and sequencer status out.
interface sap1_microsequencer_if #(
  parameter int UPC_W = 5,
  parameter int OPC_W = 4
);
  logic             run;
  logic [OPC_W-1:0] IR_OPC_i;
  logic             EP;
  logic             CP;
  logic             LM;
  logic             CE_o;
  logic             LI_o;
  logic             EI_o;
  logic             LA_o;
  logic             EA_o;
  logic             SU_o;
  logic             EU_o;
  logic             LB_o;
  logic             LO_o;
  logic             LOAD_o;
  logic             INC_o;
  logic             CLR_o;
  logic [UPC_W-1:0] UPC_o;
  logic             HLT_o;
  logic             ILL_o;

  modport master (
    input  run, IR_OPC_i,
    output EP, CP, LM, CE_o, LI_o, EI_o, LA_o, EA_o, SU_o, EU_o, LB_o, LO_o,
    output LOAD_o, INC_o, CLR_o, UPC_o, HLT_o, ILL_o
  );

  modport slave (
    output run, IR_OPC_i,
    input  EP, CP, LM, CE_o, LI_o, EI_o, LA_o, EA_o, SU_o, EU_o, LB_o, LO_o,
    input  LOAD_o, INC_o, CLR_o, UPC_o, HLT_o, ILL_o
  );
endinterface

// File: rtl/sap1_ucode_rom.sv
// Control store (combinational, indexed by the micro-PC) and the decoder that
// turns a micro-op into datapath strobes. Each word drives at most one bus source.
module sap1_ucode_rom
  import sap1_ucode_pkg::*;
#(
  parameter int UPC_W = UPC_W_DEF
) (
  input  logic [UPC_W-1:0] upc,
  output uop_t             uop,
  output seq_t             seq,
  output strobes_t         strobes
);

  uword_t word;

  // Control store contents: fetch/decode, then one routine per instruction
  always_comb begin
    word = {UOP_NOP, SEQ_CLR};
    case (int'(upc))
      0:       word = {UOP_EP_LM, SEQ_INC};
      1:       word = {UOP_CP,    SEQ_INC};
      2:       word = {UOP_CE_LI, SEQ_INC};
      3:       word = {UOP_NOP,   SEQ_MAP};
      4:       word = {UOP_EI_LM, SEQ_INC};
      5:       word = {UOP_CE_LA, SEQ_CLR};
      6:       word = {UOP_EI_LM, SEQ_INC};
      7:       word = {UOP_CE_LB, SEQ_INC};
      8:       word = {UOP_ADD,   SEQ_CLR};
      9:       word = {UOP_EI_LM, SEQ_INC};
      10:      word = {UOP_CE_LB, SEQ_INC};
      11:      word = {UOP_SUB,   SEQ_CLR};
      12:      word = {UOP_EA_LO, SEQ_CLR};
      13:      word = {UOP_HALT,  SEQ_HOLD};
      14:      word = {UOP_ILL,   SEQ_CLR};
      default: word = {UOP_NOP,   SEQ_CLR};
    endcase
  end

  assign uop = word.uop;
  assign seq = word.seq;

  // Micro-op to strobe decode; HALT and ILL only affect the sticky flags upstream
  always_comb begin
    strobes = '0;
    case (uop)
      UOP_EP_LM: begin strobes.ep = 1'b1; strobes.lm = 1'b1; end
      UOP_CP:    strobes.cp = 1'b1;
      UOP_CE_LI: begin strobes.ce = 1'b1; strobes.li = 1'b1; end
      UOP_EI_LM: begin strobes.ei = 1'b1; strobes.lm = 1'b1; end
      UOP_CE_LA: begin strobes.ce = 1'b1; strobes.la = 1'b1; end
      UOP_CE_LB: begin strobes.ce = 1'b1; strobes.lb = 1'b1; end
      UOP_ADD:   begin strobes.eu = 1'b1; strobes.la = 1'b1; end
      UOP_SUB:   begin strobes.su = 1'b1; strobes.eu = 1'b1; strobes.la = 1'b1; end
      UOP_EA_LO: begin strobes.ea = 1'b1; strobes.lo = 1'b1; end
      default:   strobes = '0;
    endcase
  end

endmodule

// File: rtl/sap1_microsequencer.sv
// SAP-1 vertical microsequencer: micro-PC register, opcode map, run gating of
// the decoded strobes, and the sticky halt / illegal-opcode flags.
module sap1_microsequencer
  import sap1_ucode_pkg::*;
#(
  parameter int UPC_W = UPC_W_DEF,
  parameter int OPC_W = OPC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  sap1_microsequencer_if.master bus
);

  logic [UPC_W-1:0] upc_reg;
  logic [UPC_W-1:0] upc_next;
  logic [UPC_W-1:0] map_target;
  logic [OPC_W-1:0] opc;
  logic             hlt_reg;
  logic             ill_reg;
  logic             active;
  uop_t             uop;
  seq_t             seq;
  strobes_t         strobes;

  sap1_ucode_rom #(.UPC_W(UPC_W)) u_rom (
    .upc     (upc_reg),
    .uop     (uop),
    .seq     (seq),
    .strobes (strobes)
  );

  assign opc = bus.IR_OPC_i;

  // A stalled or resetting cycle must not fire any strobe or sequencing action
  assign active = bus.run & ~rst;

  // Opcode to routine entry point; unknown opcodes land on the illegal trap word
  always_comb begin
    map_target = UPC_W'(ILL_BASE);
    case (opc)
      OPC_W'(OPC_LDA): map_target = UPC_W'(LDA_BASE);
      OPC_W'(OPC_ADD): map_target = UPC_W'(ADD_BASE);
      OPC_W'(OPC_SUB): map_target = UPC_W'(SUB_BASE);
      OPC_W'(OPC_OUT): map_target = UPC_W'(OUT_BASE);
      OPC_W'(OPC_HLT): map_target = UPC_W'(HLT_BASE);
      default:         map_target = UPC_W'(ILL_BASE);
    endcase
  end

  // Next micro-PC from the word's sequencing field; a bubble holds the micro-PC
  always_comb begin
    upc_next = upc_reg;
    if (bus.run) begin
      case (seq)
        SEQ_INC:  upc_next = upc_reg + 1'b1;
        SEQ_MAP:  upc_next = map_target;
        SEQ_CLR:  upc_next = UPC_W'(FETCH_BASE);
        default:  upc_next = upc_reg;
      endcase
    end
  end

  // Micro-PC and sticky flags; flags latch when their trap word actually executes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upc_reg <= '0;
      hlt_reg <= 1'b0;
      ill_reg <= 1'b0;
    end else begin
      upc_reg <= upc_next;
      if (bus.run && uop == UOP_HALT) hlt_reg <= 1'b1;
      if (bus.run && uop == UOP_ILL)  ill_reg <= 1'b1;
    end
  end

  assign bus.EP     = active & strobes.ep;
  assign bus.CP     = active & strobes.cp;
  assign bus.LM     = active & strobes.lm;
  assign bus.CE_o   = active & strobes.ce;
  assign bus.LI_o   = active & strobes.li;
  assign bus.EI_o   = active & strobes.ei;
  assign bus.LA_o   = active & strobes.la;
  assign bus.EA_o   = active & strobes.ea;
  assign bus.SU_o   = active & strobes.su;
  assign bus.EU_o   = active & strobes.eu;
  assign bus.LB_o   = active & strobes.lb;
  assign bus.LO_o   = active & strobes.lo;
  assign bus.LOAD_o = active & (seq == SEQ_MAP);
  assign bus.INC_o  = active & (seq == SEQ_INC);
  assign bus.CLR_o  = active & (seq == SEQ_CLR);
  assign bus.UPC_o  = upc_reg;
  assign bus.HLT_o  = hlt_reg;
  assign bus.ILL_o  = ill_reg;

endmodule

// File: tb/tb_sap1_microsequencer.sv
// Bench for sap1_microsequencer: a table of spec-derived vectors, hand-written
// reset sequences, and randomized run/opcode stimulus against an
// instruction-level reference model.
module tb_sap1_microsequencer;
  import sap1_ucode_pkg::*;

  // Observation word: {strobes[11:0], LOAD, INC, CLR, UPC[4:0], HLT, ILL}
  typedef logic [21:0] obs_t;

  typedef struct {
    logic       run;
    logic [3:0] opc;
    obs_t       exp;
    string      name;
  } vec_t;

  localparam logic [11:0] S_EP = 12'h800;
  localparam logic [11:0] S_CP = 12'h400;
  localparam logic [11:0] S_LM = 12'h200;
  localparam logic [11:0] S_CE = 12'h100;
  localparam logic [11:0] S_LI = 12'h080;
  localparam logic [11:0] S_EI = 12'h040;
  localparam logic [11:0] S_LA = 12'h020;
  localparam logic [11:0] S_EA = 12'h010;
  localparam logic [11:0] S_SU = 12'h008;
  localparam logic [11:0] S_EU = 12'h004;
  localparam logic [11:0] S_LB = 12'h002;
  localparam logic [11:0] S_LO = 12'h001;

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_LOAD = 3'b100;
  localparam logic [2:0] F_INC  = 3'b010;
  localparam logic [2:0] F_CLR  = 3'b001;

  localparam int C_LDA = 0;
  localparam int C_ADD = 1;
  localparam int C_SUB = 2;
  localparam int C_OUT = 3;
  localparam int C_HLT = 4;
  localparam int C_ILL = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  vec_t       tbl[$];
  int         m_step;
  int         m_cls;
  bit         m_hlt;
  bit         m_ill;
  int         hold_cnt;
  logic       r_run;
  logic [3:0] r_opc;

  sap1_microsequencer_if bus_if ();

  sap1_microsequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [11:0] s, input logic [2:0] f,
                              input int u, input bit h, input bit i);
    return {s, f, 5'(u), h, i};
  endfunction

  function automatic obs_t act_obs();
    return {bus_if.EP, bus_if.CP, bus_if.LM, bus_if.CE_o, bus_if.LI_o, bus_if.EI_o,
            bus_if.LA_o, bus_if.EA_o, bus_if.SU_o, bus_if.EU_o, bus_if.LB_o, bus_if.LO_o,
            bus_if.LOAD_o, bus_if.INC_o, bus_if.CLR_o, bus_if.UPC_o,
            bus_if.HLT_o, bus_if.ILL_o};
  endfunction

  // ---------------- instruction-level reference model ----------------
  function automatic int opc_class(input logic [3:0] o);
    case (o)
      4'd0:    return C_LDA;
      4'd1:    return C_ADD;
      4'd2:    return C_SUB;
      4'd14:   return C_OUT;
      4'd15:   return C_HLT;
      default: return C_ILL;
    endcase
  endfunction

  function automatic int routine_base(input int c);
    case (c)
      C_LDA:   return 4;
      C_ADD:   return 6;
      C_SUB:   return 9;
      C_OUT:   return 12;
      C_HLT:   return 13;
      default: return 14;
    endcase
  endfunction

  function automatic int routine_len(input int c);
    case (c)
      C_LDA:        return 2;
      C_ADD, C_SUB: return 3;
      default:      return 1;
    endcase
  endfunction

  function automatic logic [11:0] fetch_pat(input int k);
    case (k)
      0:       return S_EP | S_LM;
      1:       return S_CP;
      2:       return S_CE | S_LI;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] routine_pat(input int c, input int idx);
    if (c == C_OUT) return S_EA | S_LO;
    if (c == C_LDA || c == C_ADD || c == C_SUB) begin
      if (idx == 0) return S_EI | S_LM;
      if (c == C_LDA) return S_CE | S_LA;
      if (idx == 1) return S_CE | S_LB;
      return (c == C_SUB) ? (S_SU | S_EU | S_LA) : (S_EU | S_LA);
    end
    return 12'h000;
  endfunction

  function automatic obs_t model_obs(input logic r);
    logic [11:0] s;
    logic [2:0]  f;
    int          u;
    int          idx;
    if (m_step < 4) begin
      s = fetch_pat(m_step);
      f = (m_step == 3) ? F_LOAD : F_INC;
      u = m_step;
    end else begin
      idx = m_step - 4;
      u   = routine_base(m_cls) + idx;
      if (m_cls == C_HLT) begin
        s = 12'h000;
        f = F_NONE;
      end else begin
        s = routine_pat(m_cls, idx);
        f = (idx == routine_len(m_cls) - 1) ? F_CLR : F_INC;
      end
    end
    if (!r) begin
      s = 12'h000;
      f = F_NONE;
    end
    return mk(s, f, u, m_hlt, m_ill);
  endfunction

  task automatic model_advance(input logic r, input logic [3:0] o);
    if (!r) return;
    if (m_step == 3) begin
      m_cls  = opc_class(o);
      m_step = 4;
    end else if (m_step < 3) begin
      m_step = m_step + 1;
    end else if (m_cls == C_HLT) begin
      m_hlt = 1'b1;
    end else if (m_step - 4 == routine_len(m_cls) - 1) begin
      if (m_cls == C_ILL) m_ill = 1'b1;
      m_step = 0;
    end else begin
      m_step = m_step + 1;
    end
  endtask

  task automatic model_reset();
    m_step = 0;
    m_cls  = C_LDA;
    m_hlt  = 1'b0;
    m_ill  = 1'b0;
  endtask

  // ---------------- checking and stimulus helpers ----------------
  task automatic check(input string name, input obs_t e);
    obs_t a;
    a = act_obs();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h required %h (upc got %0d required %0d)",
               name, a, e, a[6:2], e[6:2]);
    end else begin
      $display("ok   %s: obs=%h upc=%0d", name, a, a[6:2]);
    end
  endtask

  // Entered just after a rising edge; drives inputs, checks at the falling edge.
  task automatic step(input logic r, input logic [3:0] o, input obs_t e,
                      input bit use_model, input string name);
    obs_t want;
    bus_if.run      = r;
    bus_if.IR_OPC_i = o;
    @(negedge clk);
    want = use_model ? model_obs(r) : e;
    check(name, want);
    @(posedge clk);
    model_advance(r, o);
    #1;
  endtask

  task automatic do_reset(input string name);
    rst        = 1'b1;
    bus_if.run = 1'b1;
    #1;
    check(name, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic add(input logic r, input logic [3:0] o, input logic [11:0] s,
                     input logic [2:0] f, input int u, input bit h, input bit i,
                     input string name);
    tbl.push_back('{r, o, mk(s, f, u, h, i), name});
  endtask

  task automatic add_fetch(input logic [3:0] o, input bit i, input string tag);
    add(1'b1, o, S_EP | S_LM, F_INC,  0, 1'b0, i, {tag, "_w0"});
    add(1'b1, o, S_CP,        F_INC,  1, 1'b0, i, {tag, "_w1"});
    add(1'b1, o, S_CE | S_LI, F_INC,  2, 1'b0, i, {tag, "_w2"});
    add(1'b1, o, 12'h000,     F_LOAD, 3, 1'b0, i, {tag, "_w3"});
  endtask

  initial begin
    bus_if.run      = 1'b0;
    bus_if.IR_OPC_i = 4'd0;
    rst             = 1'b1;
    hold_cnt        = 0;
    model_reset();

    // Expected vectors straight from the control-store description
    add_fetch(4'd0, 1'b0, "lda");
    add(1'b1, 4'd0, S_EI | S_LM, F_INC, 4, 1'b0, 1'b0, "lda_w4");
    add(1'b1, 4'd0, S_CE | S_LA, F_CLR, 5, 1'b0, 1'b0, "lda_w5");
    add_fetch(4'd1, 1'b0, "add");
    add(1'b1, 4'd1, S_EI | S_LM,        F_INC, 6, 1'b0, 1'b0, "add_w6");
    add(1'b1, 4'd1, S_CE | S_LB,        F_INC, 7, 1'b0, 1'b0, "add_w7");
    add(1'b1, 4'd1, S_EU | S_LA,        F_CLR, 8, 1'b0, 1'b0, "add_w8");
    add_fetch(4'd2, 1'b0, "sub");
    add(1'b1, 4'd2, S_EI | S_LM,        F_INC, 9,  1'b0, 1'b0, "sub_w9");
    add(1'b1, 4'd2, S_CE | S_LB,        F_INC, 10, 1'b0, 1'b0, "sub_w10");
    add(1'b1, 4'd2, S_SU | S_EU | S_LA, F_CLR, 11, 1'b0, 1'b0, "sub_w11");
    add_fetch(4'd14, 1'b0, "out");
    add(1'b1, 4'd14, S_EA | S_LO, F_CLR, 12, 1'b0, 1'b0, "out_w12");
    add(1'b1, 4'd0, S_EP | S_LM, F_INC,  0, 1'b0, 1'b0, "stall_w0");
    for (int k = 0; k < 3; k++)
      add(1'b0, 4'd0, 12'h000, F_NONE, 1, 1'b0, 1'b0, "stall_bubble");
    add(1'b1, 4'd0, S_CP,        F_INC,  1, 1'b0, 1'b0, "stall_resume_cp");
    add(1'b1, 4'd0, S_CE | S_LI, F_INC,  2, 1'b0, 1'b0, "stall_w2");
    add(1'b1, 4'd0, 12'h000,     F_LOAD, 3, 1'b0, 1'b0, "stall_w3");
    add(1'b1, 4'd0, S_EI | S_LM, F_INC,  4, 1'b0, 1'b0, "stall_w4");
    add(1'b1, 4'd0, S_CE | S_LA, F_CLR,  5, 1'b0, 1'b0, "stall_w5");
    add_fetch(4'd5, 1'b0, "ill");
    add(1'b1, 4'd5, 12'h000, F_CLR, 14, 1'b0, 1'b0, "ill_w14");
    add_fetch(4'd15, 1'b1, "hlt");
    add(1'b1, 4'd15, 12'h000, F_NONE, 13, 1'b0, 1'b1, "hlt_enter");
    for (int k = 0; k < 10; k++)
      add(1'b1, 4'd15, 12'h000, F_NONE, 13, 1'b1, 1'b1, "hlt_hold");

    // Reset state, including gating of run while rst is held
    @(posedge clk);
    #1;
    check("reset_state", '0);
    bus_if.run = 1'b1;
    #1;
    check("reset_gates_run", '0);
    rst = 1'b0;
    model_reset();

    foreach (tbl[i]) step(tbl[i].run, tbl[i].opc, tbl[i].exp, 1'b0, tbl[i].name);

    // Reset releases the halt trap and both sticky flags
    do_reset("hlt_rst_clear");
    step(1'b1, 4'd1, mk(S_EP | S_LM, F_INC, 0, 1'b0, 1'b0), 1'b0, "post_hlt_w0");

    // Asynchronous reset in the middle of an ADD routine at word 7
    step(1'b1, 4'd1, '0, 1'b1, "adda_w1");
    step(1'b1, 4'd1, '0, 1'b1, "adda_w2");
    step(1'b1, 4'd1, '0, 1'b1, "adda_w3");
    step(1'b1, 4'd1, '0, 1'b1, "adda_w6");
    bus_if.run = 1'b1;
    @(negedge clk);
    check("pre_rst_w7", mk(S_CE | S_LB, F_INC, 7, 1'b0, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_mid", '0);
    @(posedge clk);
    #1;
    check("rst_held_edge", '0);
    rst = 1'b0;
    model_reset();
    step(1'b1, 4'd0, mk(S_EP | S_LM, F_INC, 0, 1'b0, 1'b0), 1'b0, "restart_w0");
    step(1'b1, 4'd0, mk(S_CP, F_INC, 1, 1'b0, 1'b0), 1'b0, "restart_w1");

    // Randomized run/opcode stimulus against the reference model
    for (int n = 0; n < 500; n++) begin
      if ((m_hlt && hold_cnt >= 4) || $urandom_range(0, 63) == 0) begin
        do_reset("rand_rst");
        hold_cnt = 0;
      end
      r_run = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       r_opc = 4'd0;
        1:       r_opc = 4'd1;
        2:       r_opc = 4'd2;
        3:       r_opc = 4'd14;
        4:       r_opc = 4'd15;
        default: r_opc = 4'($urandom);
      endcase
      step(r_run, r_opc, '0, 1'b1, "rand");
      if (m_hlt) hold_cnt++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
